// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: sequencer state encoding and per-program start addresses.
package prog_seq_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
   localparam logic [3:0][15:0] PROG_ADDR = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
endpackage

// File: rtl/sat_counter.sv
// sat_counter: 16-bit up counter with synchronous clear that sticks at all-ones.
module sat_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   output logic [15:0] cnt
);
   logic [15:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? 16'h0000 : (en && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= 16'h0000;
      else cnt_q <= cnt_d;
   assign cnt = cnt_q;
endmodule

// File: rtl/prog_seq.sv
// prog_seq: program sequencer loading the PC and running until a halt instruction.
// Define PROG_SEQ_CYCLE_COUNT_EN to count RUN cycles on Cycle_cnt; otherwise it reads zero.
module prog_seq
   import prog_seq_pkg::*;
(
   input  logic        CLK,
   input  logic        Reset_n,
   input  logic        Start,
   input  logic [1:0]  Prog_sel,
   input  logic        Halt_instr,
   output logic        PC_init,
   output logic [15:0] Start_addr,
   output logic        PC_halt,
   output logic        Busy,
   output logic        Ack,
   output logic [15:0] Cycle_cnt
);
   state_t     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   always_comb begin
      state_d = (state_q == IDLE && Start)      ? LOAD :
                (state_q == LOAD)               ? RUN  :
                (state_q == RUN && Halt_instr)  ? DONE :
                (state_q == DONE && !Start)     ? IDLE : state_q;
      sel_d   = (state_q == IDLE && Start) ? Prog_sel : sel_q;
   end
   always_ff @(posedge CLK or negedge Reset_n)
      if (!Reset_n) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   assign PC_init    = state_q == LOAD;
   assign Busy       = state_q == LOAD || state_q == RUN;
   assign Ack        = state_q == DONE;
   // In RUN the PC freezes on the halt instruction itself, in the same cycle.
   assign PC_halt    = (state_q == RUN) ? Halt_instr : (state_q != LOAD);
   assign Start_addr = PROG_ADDR[sel_q];
`ifdef PROG_SEQ_CYCLE_COUNT_EN
   sat_counter u_cnt (
      .clk   (CLK),
      .rst_n (Reset_n),
      .clr   (state_q == LOAD),
      .en    (state_q == RUN),
      .cnt   (Cycle_cnt)
   );
`else
   assign Cycle_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_prog_seq.sv
// tb_prog_seq: directed self-checking bench for prog_seq (both PROG_SEQ_CYCLE_COUNT_EN builds).
module tb_prog_seq;
   logic        CLK = 1'b0;
   logic        Reset_n, Start, Halt_instr;
   logic [1:0]  Prog_sel;
   logic        PC_init, PC_halt, Busy, Ack;
   logic [15:0] Start_addr, Cycle_cnt;
   int n_chk = 0, n_fail = 0;

   prog_seq dut (
      .CLK        (CLK),
      .Reset_n    (Reset_n),
      .Start      (Start),
      .Prog_sel   (Prog_sel),
      .Halt_instr (Halt_instr),
      .PC_init    (PC_init),
      .Start_addr (Start_addr),
      .PC_halt    (PC_halt),
      .Busy       (Busy),
      .Ack        (Ack),
      .Cycle_cnt  (Cycle_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   function automatic logic [15:0] exp_cnt(input logic [15:0] n);
`ifdef PROG_SEQ_CYCLE_COUNT_EN
      return n;
`else
      return 16'h0000;
`endif
   endfunction

   initial begin
      Reset_n = 1'b0; Start = 1'b0; Prog_sel = 2'd0; Halt_instr = 1'b0;
      #12;
      check("rst_pc_init", PC_init, 0);
      check("rst_pc_halt", PC_halt, 1);
      check("rst_busy", Busy, 0);
      check("rst_ack", Ack, 0);
      check("rst_addr", Start_addr, 16'h0000);
      check("rst_cnt", Cycle_cnt, 16'h0000);
      // Start already high when reset releases: accepted on the first edge
      Start = 1'b1; Prog_sel = 2'd2;
      #1 Reset_n = 1'b1;
      tick();
      check("load_pc_init", PC_init, 1);
      check("load_addr", Start_addr, 16'h0200);
      check("load_busy", Busy, 1);
      check("load_pc_halt", PC_halt, 0);
      Prog_sel = 2'd3;
      tick();
      check("run1_pc_init", PC_init, 0);
      check("run1_busy", Busy, 1);
      check("run1_pc_halt", PC_halt, 0);
      check("run1_addr", Start_addr, 16'h0200);
      repeat (9) tick();
      Halt_instr = 1'b1;
      #1;
      check("halt_pc_halt", PC_halt, 1);
      check("halt_busy", Busy, 1);
      check("halt_ack", Ack, 0);
      tick();
      check("done_ack", Ack, 1);
      check("done_busy", Busy, 0);
      check("done_pc_halt", PC_halt, 1);
      check("done_cnt10", Cycle_cnt, exp_cnt(16'd10));
      check("done_addr", Start_addr, 16'h0200);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_ack", Ack, 1);
         check("hold_pc_init", PC_init, 0);
      end
      Halt_instr = 1'b0;
      Start = 1'b0;
      tick();
      check("idle_ack", Ack, 0);
      check("idle_busy", Busy, 0);
      check("idle_cnt_hold", Cycle_cnt, exp_cnt(16'd10));
      Start = 1'b1; Prog_sel = 2'd1;
      tick();
      check("load2_pc_init", PC_init, 1);
      check("load2_addr", Start_addr, 16'h0100);
      tick();
      check("run2_cnt_clr", Cycle_cnt, 16'h0000);
      Start = 1'b0;
      repeat (3) tick();
      check("run2_busy", Busy, 1);
      Halt_instr = 1'b1;
      tick();
      Halt_instr = 1'b0;
      check("done2_ack", Ack, 1);
      check("done2_cnt4", Cycle_cnt, exp_cnt(16'd4));
      tick();
      check("idle2_ack", Ack, 0);
      // Prog_sel change and Start drop during RUN are both ignored
      Start = 1'b1; Prog_sel = 2'd0;
      tick();
      check("load3_addr", Start_addr, 16'h0000);
      Prog_sel = 2'd3;
      tick();
      Start = 1'b0;
      repeat (4) tick();
      check("run3_addr", Start_addr, 16'h0000);
      check("run3_busy", Busy, 1);
      Halt_instr = 1'b1;
      tick();
      Halt_instr = 1'b0;
      check("done3_ack", Ack, 1);
      tick();
      // Reset pulse between edges in the middle of RUN
      Start = 1'b1; Prog_sel = 2'd3;
      tick();
      check("load4_addr", Start_addr, 16'h0300);
      tick();
      Start = 1'b0;
      tick();
      check("run4_busy", Busy, 1);
      #1 Reset_n = 1'b0;
      #1;
      check("arst_pc_halt", PC_halt, 1);
      check("arst_busy", Busy, 0);
      check("arst_addr", Start_addr, 16'h0000);
      check("arst_cnt", Cycle_cnt, 16'h0000);
      tick();
      #1 Reset_n = 1'b1;
      Halt_instr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_ack", Ack, 0);
         check("post_rst_busy", Busy, 0);
      end
      Halt_instr = 1'b0;
`ifdef PROG_SEQ_CYCLE_COUNT_EN
      Start = 1'b1; Prog_sel = 2'd1;
      tick();
      tick();
      Start = 1'b0;
      repeat (70000) @(posedge CLK);
      #2;
      check("sat_run_cnt", Cycle_cnt, 16'hFFFF);
      check("sat_busy", Busy, 1);
      Halt_instr = 1'b1;
      tick();
      Halt_instr = 1'b0;
      check("sat_done_cnt", Cycle_cnt, 16'hFFFF);
      check("sat_done_ack", Ack, 1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/prog_seq.md
PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 SHALL have port CLK  input  1  single clock, all state changes on posedge.
REQ-002 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port Start  input  1  level request from host/bench to run a program.
REQ-004 SHALL have port Prog_sel  input  2  program index 0..3, sampled when the request is accepted.
REQ-005 SHALL have port Halt_instr  input  1  decoder flag: the instruction at the current PC is halt.
REQ-006 SHALL have port PC_init  output  1  one-cycle load strobe to the program counter.
REQ-007 SHALL have port Start_addr  output  16  PC load value, valid whenever PC_init=1.
REQ-008 SHALL have port PC_halt  output  1  1 freezes the PC, 0 lets it run.
REQ-009 SHALL have port Busy  output  1  a program is loading or running.
REQ-010 SHALL have port Ack  output  1  program finished; held until Start drops.
REQ-011 SHALL have port Cycle_cnt  output  16  run-length count (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, RUN, DONE, with a registered state.
REQ-013 IDLE: PC_halt=1, Busy=0, Ack=0; Start=1 -> LOAD next cycle, Prog_sel latched that same edge.
REQ-014 LOAD (exactly 1 cycle): PC_init=1, PC_halt=0, Busy=1, Start_addr=PROG_ADDR[latched sel]; -> RUN unconditionally.
REQ-015 RUN: Busy=1, PC_halt = Halt_instr (combinational), so the PC stays on the halt instruction; Halt_instr=1 -> DONE next cycle.
REQ-016 DONE: PC_halt=1, Busy=0, Ack=1; Start=0 -> IDLE next cycle; Start held high keeps DONE indefinitely.
REQ-017 Start deassertion during LOAD or RUN SHALL be ignored; there is no abort.
REQ-018 Prog_sel changes after acceptance SHALL NOT affect Start_addr until the next accepted request.
REQ-019 Halt_instr SHALL be ignored in IDLE, LOAD and DONE.
REQ-020 Start_addr SHALL drive the latched program's address in every state (not only LOAD).
REQ-021 A new program SHALL NOT start without passing through IDLE (Start low for >=1 cycle after Ack).

Reset
REQ-022 Reset_n=0 SHALL immediately force state IDLE, latched sel 0, Cycle_cnt 0, independent of CLK.
REQ-023 Outputs during and after reset: PC_init=0, PC_halt=1, Busy=0, Ack=0, Start_addr=PROG_ADDR[0], Cycle_cnt=0.
REQ-024 Reset asserted mid-RUN SHALL abandon the program; no Ack is produced.
REQ-025 After Reset_n rises, a Start already high SHALL be accepted on the first posedge.

Configuration
REQ-026 Macro PROG_SEQ_CYCLE_COUNT_EN SHALL gate the cycle counter.
REQ-027 Defined: Cycle_cnt cleared in LOAD, +1 every RUN cycle including the halt cycle, saturates at 16'hFFFF, holds in DONE and IDLE until the next LOAD.
REQ-028 Undefined: no counter register; Cycle_cnt tied to 16'h0000; port list unchanged.

Structure
REQ-029 Shared package prog_seq_pkg SHALL hold the state enum (IDLE, LOAD, RUN, DONE) and constant array PROG_ADDR[4] of 16 bits = 16'h0000, 16'h0100, 16'h0200, 16'h0300.
REQ-030 The saturating counter SHALL be a sub-module sat_counter (16-bit, clear, enable), instantiated only under PROG_SEQ_CYCLE_COUNT_EN.
REQ-031 All other logic SHALL stay flat in prog_seq.

Verification
REQ-032 Reset then Start=1, Prog_sel=2 -> PC_init=1 with Start_addr=16'h0200 exactly 1 cycle later, Busy=1 the same cycle.
REQ-033 In RUN, Halt_instr=1 at run cycle 10 -> PC_halt=1 that same cycle, Ack=1 next cycle, Cycle_cnt=10 (macro on) or 0 (off).
REQ-034 Ack high and Start held high 5 cycles -> Ack stays 1, no PC_init; Start=0 -> IDLE, then Start=1, Prog_sel=1 -> Start_addr=16'h0100.
REQ-035 Prog_sel changed 0->3 during RUN and Start dropped mid-RUN -> Start_addr stays 16'h0000, Busy stays 1 until halt.
REQ-036 Reset_n pulsed low mid-RUN between clock edges -> PC_halt=1, Busy=0 immediately, no Ack afterward.
REQ-037 RUN held 70000 cycles without halt (macro on) -> Cycle_cnt saturates at 16'hFFFF.
